mem_hub: RTL and testbench
==========================

// Module: mem_hub
// PURPOSE
//  Single-clock memory hub between the host bus and the FPGA core. Holds three RAMs:
//  controller register RAM (true dual-port), duty/asin table (16b write, 8b read) and a
//  double-buffered modulation RAM (2 segments). Also latches write-segment/page selectors.
// PARAMETERS
//  SEL_CTL      2'd0   BUS_SEL code for the controller RAM
//  SEL_MOD      2'd1   BUS_SEL code for the modulation RAM
//  SEL_DUTY     2'd2   BUS_SEL code for the duty table (2'd3: reserved, no RAM enabled)
//  ADDR_MOD_SEG 8'h20  controller address that sets mod_wr_seg
//  ADDR_DUTY_PG 8'h21  controller address that sets duty_wr_page
// PORTS
//  CLK          in   1   single clock for every port
//  RST_N        in   1   asynchronous active-low reset
//  BUS_EN       in   1   host access enable
//  BUS_WE       in   1   host write enable (qualified by BUS_EN)
//  BUS_SEL      in   2   target RAM select
//  BUS_ADDR     in   14  host word address
//  BUS_DIN      in   16  host write data
//  BUS_DOUT     out  16  controller RAM read data, host side
//  CNT_WE       in   1   core write, controller RAM
//  CNT_ADDR     in   8   core address, controller RAM
//  CNT_DIN      in   16  core write data
//  CNT_DOUT     out  16  core read data, controller RAM
//  DUTY_IDX     in   16  duty table byte index
//  DUTY_VALUE   out  8   duty table byte
//  MOD_SEGMENT  in   1   modulation segment to read
//  MOD_IDX      in   15  modulation byte index
//  MOD_VALUE    out  8   modulation byte
//  MOD_WR_SEG   out  1   current host write segment for modulation
//  DUTY_WR_PAGE out  1   current host write page for the duty table
// BEHAVIOUR
//  - Enables: ctl_en=BUS_EN&(BUS_SEL==SEL_CTL); duty_en=BUS_EN&(BUS_SEL==SEL_DUTY);
//    mod_en[s]=BUS_EN&(BUS_SEL==SEL_MOD)&(MOD_WR_SEG==s). At most one is active per cycle.
//  - Controller RAM: 256x16. Host side uses BUS_ADDR[7:0]; core side uses CNT_*.
//    Both ports are read-first with 1-cycle registered read. BUS_DOUT updates only when ctl_en=1.
//    CNT_DOUT updates every cycle. If both sides write the same address in one cycle, the core
//    write (CNT_*) wins.
//  - Duty table: 32768x16 write words at {DUTY_WR_PAGE,BUS_ADDR}. Read is byte-addressed,
//    65536x8, little-endian: DUTY_VALUE=word[DUTY_IDX>>1] byte (DUTY_IDX[0]?[15:8]:[7:0]).
//    Registered, 1-cycle latency.
//  - Mod RAM: two segments of 16384x16 words, written at BUS_ADDR. Read is byte-indexed
//    (32768x8) with the same little-endian rule. MOD_SEGMENT is registered together with
//    MOD_IDX, so MOD_VALUE is the byte of the segment requested 1 cycle earlier.
//  - Host writes do not read back on BUS_DOUT except for the controller RAM.
//    Read during a same-cycle write to the same word returns the old data.
//  - Selector latch: 3-bit shift register sh<={sh[1:0],BUS_WE&ctl_en}.
//    When sh==3'b011 and BUS_ADDR[7:0]==ADDR_MOD_SEG: MOD_WR_SEG<=BUS_DIN[0].
//    When sh==3'b011 and BUS_ADDR[7:0]==ADDR_DUTY_PG: DUTY_WR_PAGE<=BUS_DIN[0].
//    Updates therefore land on the 3rd consecutive write cycle; host write strobes must last >=3 cycles.
//    The value is also written into the controller RAM as a normal write.
//  - Reset (RST_N=0, async): BUS_DOUT, CNT_DOUT, DUTY_VALUE, MOD_VALUE, MOD_WR_SEG,
//    DUTY_WR_PAGE and sh go to 0. RAM contents are not cleared.
//    A write in progress at reset is dropped.
//  - Address wrap: indices are modulo RAM depth; no out-of-range state exists.
// CONFIGURATION
//  MEM_HUB_ASSERT_EN defined: each CLK, an assertion requires popcount({ctl_en,duty_en,
//    mod_en[0],mod_en[1]})<=1. On failure: $error with the enable vector, then $finish.
//  Not defined: no check; behaviour is undefined if multiple enables are driven.
//  Logic is otherwise identical.
// TESTING
//  1 Reset -> all outputs 0; MOD_WR_SEG=0; DUTY_WR_PAGE=0.
//  2 Host writes ctl[5]=16'hBEEF. Core reads CNT_ADDR=5 -> CNT_DOUT=16'hBEEF 1 cycle later.
//    Core writes ctl[6]=16'h1234. Host reads 6 -> BUS_DOUT=16'h1234.
//  3 Host writes mod seg0 word 0=16'hA1B2. Host writes ADDR_MOD_SEG=1 (3-cycle strobe),
//    then mod word 0=16'h0C0D. Reads: MOD_SEGMENT=0,IDX=0 -> 8'hB2; IDX=1 -> 8'hA1;
//    MOD_SEGMENT=1,IDX=0 -> 8'h0D.
//  4 Host writes duty page1 word 3=16'h7F80 (ADDR_DUTY_PG=1 first).
//    DUTY_IDX=16'h8007 -> 8'h7F; 16'h8006 -> 8'h80.
//  5 Same-cycle host and core writes to ctl[9] (1111 vs 2222) -> ctl[9]=16'h2222.
//    A 2-cycle strobe to ADDR_MOD_SEG leaves MOD_WR_SEG unchanged.
//  6 MEM_HUB_ASSERT_EN defined; drive ctl_en and mod_en together -> $error reported;
//    with the macro undefined, no error.

Source files
------------

// File: rtl/mem_hub.sv
// Memory hub between the host bus and the FPGA core: controller register RAM, duty table
// and double-buffered modulation RAM. Define MEM_HUB_ASSERT_EN to enable the one-hot enable check.
module mem_hub #(
    parameter logic [1:0] SEL_CTL      = 2'd0,
    parameter logic [1:0] SEL_MOD      = 2'd1,
    parameter logic [1:0] SEL_DUTY     = 2'd2,
    parameter logic [7:0] ADDR_MOD_SEG = 8'h20,
    parameter logic [7:0] ADDR_DUTY_PG = 8'h21
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        BUS_EN,
    input  logic        BUS_WE,
    input  logic [1:0]  BUS_SEL,
    input  logic [13:0] BUS_ADDR,
    input  logic [15:0] BUS_DIN,
    output logic [15:0] BUS_DOUT,
    input  logic        CNT_WE,
    input  logic [7:0]  CNT_ADDR,
    input  logic [15:0] CNT_DIN,
    output logic [15:0] CNT_DOUT,
    input  logic [15:0] DUTY_IDX,
    output logic [7:0]  DUTY_VALUE,
    input  logic        MOD_SEGMENT,
    input  logic [14:0] MOD_IDX,
    output logic [7:0]  MOD_VALUE,
    output logic        MOD_WR_SEG,
    output logic        DUTY_WR_PAGE
);

    logic [15:0] r_ctl_mem  [256];
    logic [15:0] r_duty_mem [32768];
    logic [15:0] r_mod_mem  [32768];
    logic [2:0]  r_sh;

    logic        w_ctl_en;
    logic        w_duty_en;
    logic [1:0]  w_mod_en;
    logic        w_host_ctl_wr;
    logic        w_duty_wr;
    logic        w_mod_wr;
    logic        w_sel_hit;
    logic [15:0] w_duty_word;
    logic [15:0] w_mod_word;

    function automatic logic [7:0] f_byte(input logic [15:0] word, input logic hi);
        return hi ? word[15:8] : word[7:0];
    endfunction

    assign w_ctl_en    = BUS_EN && (BUS_SEL == SEL_CTL);
    assign w_duty_en   = BUS_EN && (BUS_SEL == SEL_DUTY);
    assign w_mod_en[0] = BUS_EN && (BUS_SEL == SEL_MOD) && !MOD_WR_SEG;
    assign w_mod_en[1] = BUS_EN && (BUS_SEL == SEL_MOD) && MOD_WR_SEG;

    // Core side wins a same-address collision, so the host write is suppressed there
    assign w_host_ctl_wr = BUS_WE && w_ctl_en && !(CNT_WE && (CNT_ADDR == BUS_ADDR[7:0]));
    assign w_duty_wr     = BUS_WE && w_duty_en;
    assign w_mod_wr      = BUS_WE && (|w_mod_en);
    assign w_sel_hit     = (r_sh == 3'b011);

    assign w_duty_word = r_duty_mem[DUTY_IDX[15:1]];
    assign w_mod_word  = r_mod_mem[{MOD_SEGMENT, MOD_IDX[14:1]}];

    // RAM writes share the reset-qualified block so a write during reset is dropped
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            BUS_DOUT     <= '0;
            CNT_DOUT     <= '0;
            DUTY_VALUE   <= '0;
            MOD_VALUE    <= '0;
            MOD_WR_SEG   <= 1'b0;
            DUTY_WR_PAGE <= 1'b0;
            r_sh         <= '0;
        end else begin
            if (w_host_ctl_wr) r_ctl_mem[BUS_ADDR[7:0]] <= BUS_DIN;
            if (CNT_WE)        r_ctl_mem[CNT_ADDR] <= CNT_DIN;
            if (w_duty_wr)     r_duty_mem[{DUTY_WR_PAGE, BUS_ADDR}] <= BUS_DIN;
            if (w_mod_wr)      r_mod_mem[{MOD_WR_SEG, BUS_ADDR}] <= BUS_DIN;

            if (w_ctl_en) BUS_DOUT <= r_ctl_mem[BUS_ADDR[7:0]];
            CNT_DOUT   <= r_ctl_mem[CNT_ADDR];
            DUTY_VALUE <= f_byte(w_duty_word, DUTY_IDX[0]);
            MOD_VALUE  <= f_byte(w_mod_word, MOD_IDX[0]);

            // Selectors move only on the third consecutive controller write cycle
            r_sh <= {r_sh[1:0], BUS_WE && w_ctl_en};
            if (w_sel_hit && (BUS_ADDR[7:0] == ADDR_MOD_SEG)) MOD_WR_SEG   <= BUS_DIN[0];
            if (w_sel_hit && (BUS_ADDR[7:0] == ADDR_DUTY_PG)) DUTY_WR_PAGE <= BUS_DIN[0];
        end
    end

`ifdef MEM_HUB_ASSERT_EN
    logic [3:0] w_en_vec;
    assign w_en_vec = {w_ctl_en, w_duty_en, w_mod_en[0], w_mod_en[1]};

    always_ff @(posedge CLK) begin
        if ($countones(w_en_vec) > 1) begin
            $error("mem_hub: multiple RAM enables active %b", w_en_vec);
            $finish;
        end
    end
`endif

endmodule

// File: tb/tb_mem_hub.sv
// Self-checking bench for mem_hub: directed scenarios plus randomized traffic against a
// behavioural model of the three RAMs and the write-selector latches.
module tb_mem_hub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        bus_en = 1'b0, bus_we = 1'b0;
    logic [1:0]  bus_sel = '0;
    logic [13:0] bus_addr = '0;
    logic [15:0] bus_din = '0;
    logic [15:0] bus_dout;
    logic        cnt_we = 1'b0;
    logic [7:0]  cnt_addr = '0;
    logic [15:0] cnt_din = '0;
    logic [15:0] cnt_dout;
    logic [15:0] duty_idx = '0;
    logic [7:0]  duty_value;
    logic        mod_segment = 1'b0;
    logic [14:0] mod_idx = '0;
    logic [7:0]  mod_value;
    logic        mod_wr_seg, duty_wr_page;

    always #5 clk = ~clk;

    mem_hub dut (
        .CLK(clk), .RST_N(rst_n),
        .BUS_EN(bus_en), .BUS_WE(bus_we), .BUS_SEL(bus_sel), .BUS_ADDR(bus_addr),
        .BUS_DIN(bus_din), .BUS_DOUT(bus_dout),
        .CNT_WE(cnt_we), .CNT_ADDR(cnt_addr), .CNT_DIN(cnt_din), .CNT_DOUT(cnt_dout),
        .DUTY_IDX(duty_idx), .DUTY_VALUE(duty_value),
        .MOD_SEGMENT(mod_segment), .MOD_IDX(mod_idx), .MOD_VALUE(mod_value),
        .MOD_WR_SEG(mod_wr_seg), .DUTY_WR_PAGE(duty_wr_page)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain word arrays plus "has been written" flags
    logic [15:0] ctl_m  [256];
    bit          ctl_v  [256];
    logic [15:0] duty_m [32768];
    bit          duty_v [32768];
    logic [15:0] mod_m  [32768];
    bit          mod_v  [32768];
    logic [15:0] e_bus, e_cnt;
    logic [7:0]  e_duty, e_mod;
    bit          e_bus_k, e_cnt_k, e_duty_k, e_mod_k;
    logic        e_seg, e_pg;
    int          run;

    task automatic idle();
        bus_en = 1'b0; bus_we = 1'b0; bus_sel = 2'd0; bus_addr = '0; bus_din = '0;
        cnt_we = 1'b0; cnt_din = '0;
    endtask

    // Apply the model for the current inputs, then advance one clock and settle
    task automatic step();
        bit ce, de, me;
        logic [7:0]  ca;
        logic [14:0] dw, mw;
        ce = bus_en && (bus_sel == 2'd0);
        de = bus_en && (bus_sel == 2'd2);
        me = bus_en && (bus_sel == 2'd1);
        ca = bus_addr[7:0];
        if (!rst_n) begin
            e_bus = '0; e_cnt = '0; e_duty = '0; e_mod = '0;
            e_bus_k = 1; e_cnt_k = 1; e_duty_k = 1; e_mod_k = 1;
            e_seg = 1'b0; e_pg = 1'b0; run = 0;
        end else begin
            if (ce) begin e_bus = ctl_m[ca]; e_bus_k = ctl_v[ca]; end
            e_cnt = ctl_m[cnt_addr]; e_cnt_k = ctl_v[cnt_addr];
            dw = duty_idx[15:1];
            e_duty = 8'(duty_m[dw] >> (duty_idx[0] ? 8 : 0)); e_duty_k = duty_v[dw];
            mw = {mod_segment, mod_idx[14:1]};
            e_mod = 8'(mod_m[mw] >> (mod_idx[0] ? 8 : 0)); e_mod_k = mod_v[mw];
            if (ce && bus_we && !(cnt_we && cnt_addr == ca)) begin ctl_m[ca] = bus_din; ctl_v[ca] = 1; end
            if (cnt_we) begin ctl_m[cnt_addr] = cnt_din; ctl_v[cnt_addr] = 1; end
            if (de && bus_we) begin duty_m[{e_pg, bus_addr}] = bus_din; duty_v[{e_pg, bus_addr}] = 1; end
            if (me && bus_we) begin mod_m[{e_seg, bus_addr}] = bus_din; mod_v[{e_seg, bus_addr}] = 1; end
            if (run == 2 && ca == 8'h20) e_seg = bus_din[0];
            if (run == 2 && ca == 8'h21) e_pg = bus_din[0];
            run = (ce && bus_we) ? ((run < 3) ? run + 1 : 3) : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) step();
        n_checks++; if (bus_dout !== 16'h0)   begin n_fail++; $display("FAIL reset_bus_dout got %h want 0000", bus_dout); end
        n_checks++; if (cnt_dout !== 16'h0)   begin n_fail++; $display("FAIL reset_cnt_dout got %h want 0000", cnt_dout); end
        n_checks++; if (duty_value !== 8'h0)  begin n_fail++; $display("FAIL reset_duty_value got %h want 00", duty_value); end
        n_checks++; if (mod_value !== 8'h0)   begin n_fail++; $display("FAIL reset_mod_value got %h want 00", mod_value); end
        n_checks++; if (mod_wr_seg !== 1'b0)  begin n_fail++; $display("FAIL reset_mod_wr_seg got %b want 0", mod_wr_seg); end
        n_checks++; if (duty_wr_page !== 1'b0) begin n_fail++; $display("FAIL reset_duty_wr_page got %b want 0", duty_wr_page); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ctl_ports();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'd5; bus_din = 16'hBEEF;
        step();
        idle(); cnt_addr = 8'd5;
        step();
        n_checks++; if (cnt_dout !== 16'hBEEF) begin n_fail++; $display("FAIL ctl_core_read got %h want beef", cnt_dout); end
        idle(); cnt_we = 1; cnt_addr = 8'd6; cnt_din = 16'h1234;
        step();
        idle(); bus_en = 1; bus_sel = 2'd0; bus_addr = 14'd6;
        step();
        n_checks++; if (bus_dout !== 16'h1234) begin n_fail++; $display("FAIL ctl_host_read got %h want 1234", bus_dout); end
        idle(); bus_en = 1; bus_sel = 2'd2; bus_addr = 14'd5;
        step();
        n_checks++; if (bus_dout !== 16'h1234) begin n_fail++; $display("FAIL bus_dout_hold got %h want 1234", bus_dout); end
    endtask

    task automatic test_mod_segments();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd1; bus_addr = 14'd0; bus_din = 16'hA1B2;
        step();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'h20; bus_din = 16'h0001;
        repeat (2) step();
        n_checks++; if (mod_wr_seg !== 1'b0) begin n_fail++; $display("FAIL mod_seg_early got %b want 0", mod_wr_seg); end
        step();
        n_checks++; if (mod_wr_seg !== 1'b1) begin n_fail++; $display("FAIL mod_seg_set got %b want 1", mod_wr_seg); end
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd1; bus_addr = 14'd0; bus_din = 16'h0C0D;
        step();
        idle(); mod_segment = 1'b0; mod_idx = 15'd0;
        step();
        n_checks++; if (mod_value !== 8'hB2) begin n_fail++; $display("FAIL mod_seg0_lo got %h want b2", mod_value); end
        mod_idx = 15'd1;
        step();
        n_checks++; if (mod_value !== 8'hA1) begin n_fail++; $display("FAIL mod_seg0_hi got %h want a1", mod_value); end
        mod_segment = 1'b1; mod_idx = 15'd0;
        step();
        n_checks++; if (mod_value !== 8'h0D) begin n_fail++; $display("FAIL mod_seg1_lo got %h want 0d", mod_value); end
    endtask

    task automatic test_duty_page();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'h21; bus_din = 16'h0001;
        repeat (3) step();
        n_checks++; if (duty_wr_page !== 1'b1) begin n_fail++; $display("FAIL duty_page_set got %b want 1", duty_wr_page); end
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd2; bus_addr = 14'd3; bus_din = 16'h7F80;
        step();
        idle(); duty_idx = 16'h8007;
        step();
        n_checks++; if (duty_value !== 8'h7F) begin n_fail++; $display("FAIL duty_hi_byte got %h want 7f", duty_value); end
        duty_idx = 16'h8006;
        step();
        n_checks++; if (duty_value !== 8'h80) begin n_fail++; $display("FAIL duty_lo_byte got %h want 80", duty_value); end
    endtask

    task automatic test_collision();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'd9; bus_din = 16'h1111;
        cnt_we = 1; cnt_addr = 8'd9; cnt_din = 16'h2222;
        step();
        idle(); bus_en = 1; bus_sel = 2'd0; bus_addr = 14'd9; cnt_addr = 8'd9;
        step();
        n_checks++; if (bus_dout !== 16'h2222) begin n_fail++; $display("FAIL collision_host got %h want 2222", bus_dout); end
        n_checks++; if (cnt_dout !== 16'h2222) begin n_fail++; $display("FAIL collision_core got %h want 2222", cnt_dout); end
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'h20; bus_din = 16'h0000;
        repeat (2) step();
        idle();
        repeat (2) step();
        n_checks++; if (mod_wr_seg !== 1'b1) begin n_fail++; $display("FAIL short_strobe got %b want 1", mod_wr_seg); end
    endtask

    task automatic test_reset_drop();
        idle(); bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = 14'd3; bus_din = 16'hAAAA; cnt_addr = 8'd9;
        step();
        bus_din = 16'h5555;
        rst_n = 1'b0;
        #1;
        n_checks++; if (cnt_dout !== 16'h0)     begin n_fail++; $display("FAIL async_cnt_dout got %h want 0000", cnt_dout); end
        n_checks++; if (mod_wr_seg !== 1'b0)   begin n_fail++; $display("FAIL async_mod_wr_seg got %b want 0", mod_wr_seg); end
        n_checks++; if (duty_wr_page !== 1'b0) begin n_fail++; $display("FAIL async_duty_wr_page got %b want 0", duty_wr_page); end
        step();
        rst_n = 1'b1;
        idle(); cnt_addr = 8'd3;
        step();
        n_checks++; if (cnt_dout !== 16'hAAAA) begin n_fail++; $display("FAIL write_in_reset got %h want aaaa", cnt_dout); end
    endtask

    task automatic test_random();
        int left = 0;
        int kind;
        logic [7:0]  sa = '0;
        logic [15:0] sd = '0;
        logic [13:0] a;
        for (int c = 0; c < 800; c++) begin
            idle();
            bus_addr = 14'($urandom_range(0, 15));
            if (left > 0) begin
                bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = {6'd0, sa}; bus_din = sd;
                left--;
            end else begin
                kind = $urandom_range(0, 9);
                a = 14'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) a[13] = 1'b1;
                if (kind <= 2) begin
                    case ($urandom_range(0, 2))
                        0: sa = 8'h20;
                        1: sa = 8'h21;
                        default: sa = 8'($urandom_range(0, 15));
                    endcase
                    sd = 16'($urandom);
                    left = $urandom_range(0, 3);
                    bus_en = 1; bus_we = 1; bus_sel = 2'd0; bus_addr = {6'd0, sa}; bus_din = sd;
                end else if (kind <= 4) begin
                    bus_en = 1; bus_we = 1; bus_sel = 2'd1; bus_addr = a; bus_din = 16'($urandom);
                end else if (kind <= 6) begin
                    bus_en = 1; bus_we = 1; bus_sel = 2'd2; bus_addr = a; bus_din = 16'($urandom);
                end else if (kind == 7) begin
                    bus_en = 1; bus_sel = 2'd0;
                end else if (kind == 8) begin
                    bus_en = 1; bus_we = 1; bus_sel = 2'd3; bus_addr = a; bus_din = 16'($urandom);
                end
            end
            cnt_we   = ($urandom_range(0, 3) == 0);
            cnt_addr = ($urandom_range(0, 7) == 0) ? 8'h20 : 8'($urandom_range(0, 15));
            cnt_din  = 16'($urandom);
            a = 14'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a[13] = 1'b1;
            duty_idx = {1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1))};
            mod_idx  = {a, 1'($urandom_range(0, 1))};
            mod_segment = 1'($urandom_range(0, 1));
            step();
            if (e_bus_k) begin
                n_checks++;
                if (bus_dout !== e_bus) begin n_fail++; $display("FAIL rnd_bus_dout cyc %0d got %h want %h", c, bus_dout, e_bus); end
            end
            if (e_cnt_k) begin
                n_checks++;
                if (cnt_dout !== e_cnt) begin n_fail++; $display("FAIL rnd_cnt_dout cyc %0d got %h want %h", c, cnt_dout, e_cnt); end
            end
            if (e_duty_k) begin
                n_checks++;
                if (duty_value !== e_duty) begin n_fail++; $display("FAIL rnd_duty cyc %0d got %h want %h", c, duty_value, e_duty); end
            end
            if (e_mod_k) begin
                n_checks++;
                if (mod_value !== e_mod) begin n_fail++; $display("FAIL rnd_mod cyc %0d got %h want %h", c, mod_value, e_mod); end
            end
            n_checks++;
            if (mod_wr_seg !== e_seg) begin n_fail++; $display("FAIL rnd_mod_wr_seg cyc %0d got %b want %b", c, mod_wr_seg, e_seg); end
            n_checks++;
            if (duty_wr_page !== e_pg) begin n_fail++; $display("FAIL rnd_duty_wr_page cyc %0d got %b want %b", c, duty_wr_page, e_pg); end
        end
    endtask

    initial begin
        test_reset();
        test_ctl_ports();
        test_mod_segments();
        test_duty_page();
        test_collision();
        test_reset_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
